// File: rtl/fastram_sdram_seq.sv
// fastram_sdram_seq: sequences CPU fast-RAM byte accesses onto one SDRAM port.
// Define FASTRAM_WRITE_POST_EN for the one-entry posted-write buffer.
module fastram_sdram_seq #(
  parameter int ACK_WINDOW = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        phase_strobe,
  input  logic        cpu_ce,
  input  logic        cpu_rnw,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_busy,
  output logic        timeout_err
);
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [22:0] req_addr_q, req_addr_d;
  logic [7:0]  req_data_q, req_data_d;
  logic        req_rnw_q, req_rnw_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  dout_q, dout_d;
  logic        wait_q, wait_d;
  logic [24:0] sd_addr_q, sd_addr_d;
  logic [7:0]  sd_din_q, sd_din_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic        terr_q, terr_d;
  logic        accept;
  logic [22:0] iss_addr;
  logic [7:0]  iss_data;
  logic        iss_rnw;
`ifdef FASTRAM_WRITE_POST_EN
  logic        wb_valid_q, wb_valid_d;
  logic [22:0] wb_addr_q, wb_addr_d;
  logic [7:0]  wb_data_q, wb_data_d;
  logic        cur_wb_q, cur_wb_d;
  logic        pend_q, pend_d;
  logic        hit;
`endif

  assign accept = phase_strobe & cpu_ce & ~wait_q;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_rnw_d  = req_rnw_q;
    data_d     = data_q;
    dout_d     = dout_q;
    wait_d     = wait_q;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    sd_rd_d    = 1'b0;
    sd_wr_d    = 1'b0;
    terr_d     = terr_q;
    iss_addr   = req_addr_q;
    iss_data   = req_data_q;
    iss_rnw    = req_rnw_q;
`ifdef FASTRAM_WRITE_POST_EN
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    cur_wb_d   = cur_wb_q;
    pend_d     = pend_q;
    hit        = wb_valid_q && (cpu_addr == wb_addr_q);
    if (cur_wb_q) begin
      iss_addr = wb_addr_q;
      iss_data = wb_data_q;
      iss_rnw  = 1'b0;
    end
    // A drain runs with cpu_wait low, so the CPU may strike mid-drain.
    if (accept && state_q != IDLE) begin
      if (cpu_rnw && hit) begin
        dout_d = wb_data_q;
      end else if (state_q != COMPLETE) begin
        req_addr_d = cpu_addr;
        req_data_d = cpu_din;
        req_rnw_d  = cpu_rnw;
        wait_d     = 1'b1;
        pend_d     = 1'b1;
      end
    end
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FASTRAM_WRITE_POST_EN
        if (accept) begin
          if (cpu_rnw && hit) begin
            dout_d = wb_data_q;
          end else if (!cpu_rnw && !wb_valid_q) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = cpu_addr;
            wb_data_d  = cpu_din;
          end else begin
            req_addr_d = cpu_addr;
            req_data_d = cpu_din;
            req_rnw_d  = cpu_rnw;
            wait_d     = 1'b1;
            state_d    = ISSUE;
            cur_wb_d   = wb_valid_q;
            pend_d     = wb_valid_q;
          end
        end else if (wb_valid_q) begin
          state_d  = ISSUE;
          cur_wb_d = 1'b1;
        end
`else
        if (accept) begin
          req_addr_d = cpu_addr;
          req_data_d = cpu_din;
          req_rnw_d  = cpu_rnw;
          wait_d     = 1'b1;
          state_d    = ISSUE;
        end
`endif
      end
      ISSUE: begin
        if (!sd_busy) begin
          sd_rd_d   = iss_rnw;
          sd_wr_d   = ~iss_rnw;
          sd_addr_d = {2'b00, iss_addr};
          if (!iss_rnw) sd_din_d = iss_data;
          cnt_d     = 8'd0;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (sd_busy) begin
          cnt_d   = 8'd0;
          state_d = WAIT_DONE;
        end else if (cnt_q == 8'(ACK_WINDOW)) begin
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!sd_busy) begin
          if (iss_rnw) data_d = sd_dout;
          state_d = COMPLETE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          terr_d  = 1'b1;
          if (iss_rnw) data_d = 8'hFF;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        wait_d  = 1'b0;
`ifdef FASTRAM_WRITE_POST_EN
        if (cur_wb_q) begin
          wb_valid_d = 1'b0;
          cur_wb_d   = 1'b0;
          if (pend_q) begin
            pend_d = 1'b0;
            if (req_rnw_q) begin
              wait_d  = 1'b1;
              state_d = ISSUE;
            end else begin
              wb_valid_d = 1'b1;
              wb_addr_d  = req_addr_q;
              wb_data_d  = req_data_q;
            end
          end else if (accept && !(cpu_rnw && hit)) begin
            if (cpu_rnw) begin
              req_addr_d = cpu_addr;
              req_rnw_d  = 1'b1;
              wait_d     = 1'b1;
              state_d    = ISSUE;
            end else begin
              wb_valid_d = 1'b1;
              wb_addr_d  = cpu_addr;
              wb_data_d  = cpu_din;
            end
          end
        end else begin
          dout_d = data_q;
        end
`else
        if (req_rnw_q) dout_d = data_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rnw_q  <= 1'b0;
      data_q     <= '0;
      dout_q     <= '0;
      wait_q     <= 1'b0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      terr_q     <= 1'b0;
`ifdef FASTRAM_WRITE_POST_EN
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cur_wb_q   <= 1'b0;
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_rnw_q  <= req_rnw_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
      wait_q     <= wait_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      terr_q     <= terr_d;
`ifdef FASTRAM_WRITE_POST_EN
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cur_wb_q   <= cur_wb_d;
      pend_q     <= pend_d;
`endif
    end
  end

  assign cpu_dout    = dout_q;
  assign cpu_wait    = wait_q;
  assign sd_addr     = sd_addr_q;
  assign sd_din      = sd_din_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign timeout_err = terr_q;
endmodule
